// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a serial transmitter through a start/data/ready handshake.
// Push is not throttled; a write into a full FIFO is dropped and flagged as a sticky overflow.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_ONE   = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  // Both decisions use the registered flags, so a same-cycle pop never frees room for a write.
  assign w_push = wr & ~r_full;
  assign w_pop  = (r_state == IDLE) & ~r_empty & tx_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      if (wr && r_full) r_overflow <= 1'b1;

      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: r_state <= BUSY;
        // Require a full busy-then-ready cycle before the next launch.
        BUSY:  if (!tx_ready) r_state <= DRAIN;
        DRAIN: if (tx_ready)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_count;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a negedge monitor matches every launch against a queue of expected bytes.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_ready = 1'b1;
  logic       tx_start;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb [$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every launch must match the oldest expected byte.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL launch_unexpected: got tx_data=%02h, expected no launch", tx_data);
        end else begin
          exp = sb.pop_front();
          if (tx_data !== exp) begin
            n_errors++;
            $display("FAIL launch_data: got %02h expected %02h", tx_data, exp);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit expect_launch);
    wr  = 1'b1;
    din = b;
    if (expect_launch) sb.push_back(b);
    tick;
    wr  = 1'b0;
  endtask

  // Transmitter behaviour after it has sampled a start pulse.
  task automatic tail;
    tick;
    tx_ready = 1'b0;
    tick;
    tick;
    tx_ready = 1'b1;
    tick;
  endtask

  task automatic serve(input int n);
    int w;
    tx_ready = 1'b1;
    for (int f = 0; f < n; f++) begin
      w = 0;
      while (!tx_start && w < 200) begin
        tick;
        w++;
      end
      n_checks++;
      if (!tx_start) begin
        n_errors++;
        $display("FAIL serve_timeout: got no tx_start in frame %0d, expected a launch", f);
        return;
      end
      tail;
    end
  endtask

  initial begin
    int cnt;
    // Reset and basic launch
    tick; tick; tick;
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);

    wr_byte(8'hA5, 1'b1);
    chk("n1_empty", empty, 0);
    chk("n1_tx_start", tx_start, 0);
    tick;
    chk("n2_tx_start", tx_start, 1);
    chk("n2_tx_data", tx_data, 8'hA5);
    chk("n2_empty", empty, 1);

    // Handshake: no second start while the transmitter stays busy
    tx_ready = 1'b0;
    wr_byte(8'h3C, 1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (tx_start) cnt++;
    end
    chk("busy_no_start", cnt, 0);
    chk("busy_level", level, 1);
    tx_ready = 1'b1;
    tick;
    chk("ready_plus1_start", tx_start, 0);
    tick;
    chk("ready_plus2_start", tx_start, 1);
    chk("ready_plus2_data", tx_data, 8'h3C);
    tail;

    // Ordering and wrap
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_byte(8'(i), 1'b1);
    tick;
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    fork
      begin
        int g;
        for (int i = 16; i < 36; i++) begin
          g = 0;
          while (full && g < 500) begin
            tick;
            g++;
          end
          wr_byte(8'(i), 1'b1);
          tick; tick; tick;
        end
      end
      begin
        serve(36);
      end
    join
    tick;
    chk("wrap_empty", empty, 1);
    chk("wrap_level", level, 0);
    chk("wrap_overflow", overflow, 0);

    // Overflow: 8'h77 is dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_byte(8'h40 + 8'(i), 1'b1);
    wr_byte(8'h77, 1'b0);
    tick;
    chk("ovf_level", level, 16);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    tick; tick;
    chk("ovf_sticky", overflow, 1);
    serve(16);
    tick;
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_sticky_after", overflow, 1);

    // Simultaneous write and pop
    tx_ready = 1'b0;
    wr_byte(8'h51, 1'b1);
    wr_byte(8'h52, 1'b1);
    wr_byte(8'h53, 1'b1);
    tick;
    chk("sim_level_before", level, 3);
    tx_ready = 1'b1;
    wr_byte(8'h54, 1'b1);
    chk("sim_level_after", level, 3);
    chk("sim_tx_start", tx_start, 1);
    chk("sim_tx_data", tx_data, 8'h51);
    tail;
    serve(3);
    tick;
    chk("sim_drained_empty", empty, 1);

    // Reset mid-operation, while BUSY with 5 bytes buffered
    tx_ready = 1'b0;
    wr_byte(8'h61, 1'b1);
    for (int i = 2; i < 7; i++) wr_byte(8'h60 + 8'(i), 1'b0);
    tick;
    tx_ready = 1'b1;
    tick;
    chk("mid_tx_start", tx_start, 1);
    tick;
    chk("mid_busy_level", level, 5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (tx_start) cnt++;
    end
    chk("mid_no_launch", cnt, 0);
    wr_byte(8'h99, 1'b1);
    serve(1);
    tick;
    chk("final_queue_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
